// File: rtl/data_cache_pkg.sv
// Shared constants for the direct-mapped, write-through, one-word-per-line data cache.
package data_cache_pkg;
   localparam int ADDR_W       = 32;
   localparam int DEFAULT_SETS = 8;
   localparam int IDX_W        = $clog2(DEFAULT_SETS);
   localparam int TAG_W        = ADDR_W - IDX_W - 2;

   typedef logic [1:0] state_t;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/data_cache_byte_lane.sv
// Byte-lane datapath: load byte extraction, store lane replication/enables,
// and merging of a completed store into a cached word.
module cache_byte_lane #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            byte_sel_i,
   input  logic                  is_byte_i,
   input  logic [DATA_WIDTH-1:0] line_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic [DATA_WIDTH-1:0] load_data_o,
   output logic [DATA_WIDTH-1:0] store_data_o,
   output logic [3:0]            store_be_o,
   input  logic [DATA_WIDTH-1:0] merge_old_i,
   input  logic [DATA_WIDTH-1:0] merge_data_i,
   input  logic [3:0]            merge_be_i,
   output logic [DATA_WIDTH-1:0] merged_o
);
   localparam int LW = DATA_WIDTH / 4;

   logic [LW-1:0] lanes [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lanes[gi] = line_i[gi*LW +: LW];
         // Byte stores place the low byte in every lane; the enable picks the real one.
         assign store_data_o[gi*LW +: LW] = is_byte_i ? cpu_wdata_i[LW-1:0]
                                                      : cpu_wdata_i[gi*LW +: LW];
         assign store_be_o[gi] = !is_byte_i || (byte_sel_i == 2'(gi));
         assign merged_o[gi*LW +: LW] = merge_be_i[gi] ? merge_data_i[gi*LW +: LW]
                                                       : merge_old_i[gi*LW +: LW];
      end
   endgenerate

   assign load_data_o = is_byte_i ? {{(DATA_WIDTH-LW){1'b0}}, lanes[byte_sel_i]} : line_i;
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-line data cache: read-allocate on load miss,
// write-through / no-write-allocate stores, single outstanding memory transaction.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = DEFAULT_SETS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_re,
   input  logic                  cpu_we,
   input  logic                  cpu_byte,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam int IW = (SETS == DEFAULT_SETS) ? IDX_W : $clog2(SETS);
   localparam int TW = (SETS == DEFAULT_SETS) ? TAG_W : ADDR_W - IW - 2;

   state_t                state_q, state_d;
   logic [SETS-1:0]       valid_q;
   logic [TW-1:0]         tag_mem  [SETS];
   logic [DATA_WIDTH-1:0] data_mem [SETS];

   logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_be_q, mem_be_d;

   logic [IW-1:0]         cpu_idx, txn_idx;
   logic [TW-1:0]         cpu_tag, txn_tag;
   logic                  cpu_hit, txn_hit, fill_done, write_done;
   logic [DATA_WIDTH-1:0] load_word, store_wdata, merged_word;
   logic [3:0]            store_be;

   // The outstanding transaction is identified by the registered memory address.
   assign cpu_idx    = cpu_addr[IW+1:2];
   assign cpu_tag    = cpu_addr[ADDR_W-1:IW+2];
   assign txn_idx    = mem_addr_q[IW+1:2];
   assign txn_tag    = mem_addr_q[ADDR_W-1:IW+2];
   assign cpu_hit    = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
   assign txn_hit    = valid_q[txn_idx] && (tag_mem[txn_idx] == txn_tag);
   assign fill_done  = (state_q == ST_FILL)  && mem_ready;
   assign write_done = (state_q == ST_WRITE) && mem_ready;

   cache_byte_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .byte_sel_i   (cpu_addr[1:0]),
      .is_byte_i    (cpu_byte),
      .line_i       (data_mem[cpu_idx]),
      .cpu_wdata_i  (cpu_wdata),
      .load_data_o  (load_word),
      .store_data_o (store_wdata),
      .store_be_o   (store_be),
      .merge_old_i  (data_mem[txn_idx]),
      .merge_data_i (mem_wdata_q),
      .merge_be_i   (mem_be_q),
      .merged_o     (merged_word)
   );

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_we) begin
               state_d     = ST_WRITE;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
               mem_wdata_d = store_wdata;
               mem_be_d    = store_be;
            end else if (cpu_re && !cpu_hit) begin
               state_d    = ST_FILL;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {cpu_addr[ADDR_W-1:2], 2'b00};
               mem_be_d   = 4'b1111;
            end
         end
         ST_FILL: begin
            if (mem_ready) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
         end
         ST_WRITE: begin
            if (mem_ready) begin
               state_d   = ST_DONE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         valid_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         if (fill_done) valid_q[txn_idx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; validity alone qualifies their contents.
   always_ff @(posedge clk) begin
      if (!rst && fill_done) begin
         tag_mem[txn_idx]  <= txn_tag;
         data_mem[txn_idx] <= mem_rdata;
      end else if (!rst && write_done && txn_hit) begin
         data_mem[txn_idx] <= merged_word;
      end
   end

   assign stall = ((state_q == ST_IDLE) && (cpu_we || (cpu_re && !cpu_hit)))
                || (state_q == ST_FILL) || (state_q == ST_WRITE);
   assign cpu_rdata = ((state_q == ST_IDLE) && cpu_re && !cpu_we && cpu_hit) ? load_word : '0;

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
endmodule

// File: tb/tb_data_cache.sv
// Randomized scoreboard bench for data_cache with a behavioural cache/memory model.
module tb_data_cache;
   localparam int DW   = 32;
   localparam int SETS = 8;

   typedef struct { logic [31:0] rdata; int stall; } exp_t;
   typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } wreq_t;

   logic          clk = 1'b0, rst = 1'b1;
   logic          cpu_re = 1'b0, cpu_we = 1'b0, cpu_byte = 1'b0;
   logic [31:0]   cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata, mem_wdata;
   logic          stall, mem_req, mem_we, mem_ready;
   logic [31:0]   mem_addr;
   logic [3:0]    mem_be;
   logic [DW-1:0] mem_rdata = '0;
   logic          resp_ready = 1'b0, force_ready = 1'b0;
   bit            resp_en = 1'b1;
   int            lat = 1;
   int            n_vec = 0, n_err = 0, n_txn = 0;

   exp_t          exp_q[$];
   wreq_t         wq[$];
   logic [31:0]   fq[$];
   logic [31:0]   ref_mem [int unsigned];
   logic [31:0]   bus_mem [int unsigned];
   bit            m_valid [SETS];
   int unsigned   m_word  [SETS];

   assign mem_ready = resp_ready | force_ready;
   always #5 clk = ~clk;

   data_cache #(.DATA_WIDTH(DW), .SETS(SETS)) dut (
      .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int unsigned wa);
      return (wa * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_rd(input int unsigned wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction

   function automatic logic [31:0] bus_rd(input int unsigned wa);
      return bus_mem.exists(wa) ? bus_mem[wa] : init_word(wa);
   endfunction

   // Issue one CPU request, predict its outcome, hold it until the cache lets go.
   task automatic issue(input bit re, input bit we, input bit byt, input logic [31:0] addr,
                        input logic [31:0] wdata, input int l);
      exp_t        e;
      wreq_t       w;
      int unsigned wa, ln;
      bit          hit;
      logic [31:0] word;
      int          cyc;
      lat = l;
      wa  = addr >> 2;
      ln  = wa % SETS;
      if (we) begin
         w.addr  = {addr[31:2], 2'b00};
         w.be    = byt ? (4'b0001 << addr[1:0]) : 4'b1111;
         w.wdata = byt ? {4{wdata[7:0]}} : wdata;
         wq.push_back(w);
         ref_mem[wa] = merge(ref_rd(wa), w.wdata, w.be);
         e.rdata = '0;
         e.stall = l + 1;
      end else begin
         hit = m_valid[ln] && (m_word[ln] == wa);
         if (!hit) begin
            fq.push_back({addr[31:2], 2'b00});
            m_valid[ln] = 1'b1;
            m_word[ln]  = wa;
         end
         word    = ref_rd(wa);
         e.rdata = byt ? ((word >> (8 * int'(addr[1:0]))) & 32'hFF) : word;
         e.stall = hit ? 0 : l + 1;
      end
      exp_q.push_back(e);
      cpu_re = re; cpu_we = we; cpu_byte = byt; cpu_addr = addr; cpu_wdata = wdata;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (stall && cyc < 100);
      if (cyc >= 100) check("issue_timeout", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      cpu_re = 1'b0; cpu_we = 1'b0;
   endtask

   // Memory responder: checks each request against what the model expects.
   initial begin
      logic [31:0]   a;
      logic [31:0]   ew;
      wreq_t         w;
      forever begin
         @(negedge clk);
         if (mem_req && !rst && resp_en) begin
            a = mem_addr;
            if (mem_we) begin
               if (wq.size() == 0) check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
               else begin
                  w = wq.pop_front();
                  check("wr_addr", mem_addr, w.addr);
                  check("wr_be", {28'd0, mem_be}, {28'd0, w.be});
                  check("wr_wdata", mem_wdata, w.wdata);
               end
            end else begin
               if (fq.size() == 0) check("unexpected_fill", mem_addr, 32'hFFFF_FFFF);
               else begin
                  ew = fq.pop_front();
                  check("fill_addr", mem_addr, ew);
               end
            end
            repeat (lat - 1) @(negedge clk);
            resp_ready = 1'b1;
            if (mem_we) bus_mem[a >> 2] = merge(bus_rd(a >> 2), mem_wdata, mem_be);
            else mem_rdata = bus_rd(a >> 2);
            @(negedge clk);
            resp_ready = 1'b0;
         end
      end
   end

   // Completion monitor: a request with stall low has been serviced.
   initial begin
      int   stall_cnt;
      exp_t e;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) stall_cnt = 0;
         else if (cpu_re || cpu_we) begin
            if (stall) begin
               stall_cnt++;
               check("rdata_while_stalled", cpu_rdata, 32'd0);
            end else begin
               if (exp_q.size() == 0) check("unexpected_completion", cpu_rdata, 32'hFFFF_FFFF);
               else begin
                  e = exp_q.pop_front();
                  n_txn++;
                  $display("txn %0d: re=%0d we=%0d byte=%0d addr=0x%08h rdata=0x%08h stall_cycles=%0d",
                           n_txn, cpu_re, cpu_we, cpu_byte, cpu_addr, cpu_rdata, stall_cnt);
                  check("cpu_rdata", cpu_rdata, e.rdata);
                  check("stall_cycles", stall_cnt, e.stall);
               end
               stall_cnt = 0;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          op;
      bit          byt;
      logic [31:0] a, d;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_be", {28'd0, mem_be}, 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      @(posedge clk); #1;

      ref_mem[32'h10] = 32'hDEAD_BEEF;
      bus_mem[32'h10] = 32'hDEAD_BEEF;
      issue(1, 0, 0, 32'h40, 32'd0, 3);
      issue(1, 0, 0, 32'h40, 32'd0, 1);
      issue(0, 1, 1, 32'h41, 32'h0000_00AB, 2);
      issue(1, 0, 1, 32'h41, 32'd0, 1);
      issue(1, 0, 0, 32'h40, 32'd0, 1);
      issue(1, 0, 0, 32'h60, 32'd0, 2);
      issue(1, 0, 0, 32'h40, 32'd0, 2);

      // Abandon a fill with reset, then pulse a late mem_ready in IDLE.
      resp_en = 1'b0;
      cpu_re = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h20;
      @(negedge clk);
      check("rt_miss_stall", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rt_fill_req", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; cpu_re = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; force_ready = 1'b1;
      for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
      @(negedge clk);
      check("rt_after_rst_req", {31'd0, mem_req}, 32'd0);
      check("rt_after_rst_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      force_ready = 1'b0;
      @(negedge clk);
      check("rt_late_ready_ignored", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      resp_en = 1'b1;
      issue(1, 0, 0, 32'h40, 32'd0, 2);
      issue(1, 0, 0, 32'h20, 32'd0, 1);

      issue(1, 1, 0, 32'h80, 32'h1234_5678, 2);
      @(negedge clk);
      check("no_second_req", {31'd0, mem_req}, 32'd0);
      check("idle_after_done_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      issue(1, 0, 0, 32'h80, 32'd0, 1);

      for (int i = 0; i < 150; i++) begin
         op  = int'($urandom_range(0, 9));
         byt = 1'($urandom_range(0, 1));
         a   = 32'($urandom_range(0, 31)) << 2;
         if (byt) a[1:0] = 2'($urandom_range(0, 3));
         d   = $urandom;
         if (op < 5)      issue(1, 0, byt, a, d, int'($urandom_range(1, 4)));
         else if (op < 8) issue(0, 1, byt, a, d, int'($urandom_range(1, 4)));
         else             issue(1, 1, byt, a, d, int'($urandom_range(1, 4)));
      end

      repeat (4) @(posedge clk);
      check("exp_q_drained", exp_q.size(), 32'd0);
      check("wq_drained", wq.size(), 32'd0);
      check("fq_drained", fq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter DATA_WIDTH, default 32, shall set the CPU and memory data word width.
REQ-002 Parameter SETS, default 8, power of two, shall set the number of direct-mapped one-word lines.
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  shall be the synchronous, active-high reset.
REQ-005 cpu_re  input  1  shall be the load request.
REQ-006 cpu_we  input  1  shall be the store request.
REQ-007 cpu_byte  input  1  shall select access size: 1 = byte, 0 = word.
REQ-008 cpu_addr  input  32  shall be the byte address.
REQ-009 cpu_wdata  input  DATA_WIDTH  shall be the store data; byte stores use bits [7:0].
REQ-010 cpu_rdata  output  DATA_WIDTH  shall be the load result; it feeds the writeback result-select input 1.
REQ-011 stall  output  1  shall freeze the pipeline while high.
REQ-012 mem_req, mem_we  output  1 each  shall be the memory request and write qualifier.
REQ-013 mem_addr  output  32  shall be the word-aligned memory address.
REQ-014 mem_wdata  output  DATA_WIDTH, mem_be  output  4  shall carry the store data and byte enables.
REQ-015 mem_ready  input  1, mem_rdata  input  DATA_WIDTH  shall carry the memory completion and read data.

Function
REQ-016 Address split shall be: index = addr[log2(SETS)+1:2]; tag = addr[31:log2(SETS)+2]; hit = valid[index] and tag match.
REQ-017 The FSM shall have exactly four states: IDLE, FILL, WRITE, DONE.
REQ-018 IDLE, cpu_re hit: cpu_rdata shall be valid combinationally in the same cycle, with stall=0 and no memory request.
REQ-019 Byte loads shall return the byte selected by addr[1:0], zero-extended.
REQ-020 IDLE, cpu_re miss: stall shall be 1 in that cycle, and the FSM shall go to FILL with mem_req=1, mem_we=0 and mem_addr={addr[31:2],2'b00}, all registered.
REQ-021 FILL: memory outputs shall be held until mem_ready=1 is sampled; at that edge the line shall take mem_rdata, the tag and valid=1, and the FSM shall go to IDLE, mem_req=0.
REQ-022 After FILL the re-presented load hits, so miss penalty shall be memory latency + 1 cycle.
REQ-023 IDLE, cpu_we: stall shall be 1, and the FSM shall go to WRITE with mem_we=1 and mem_req=1 (write-through, no-write-allocate).
REQ-024 Word store: mem_be=4'b1111. Byte store: mem_be one-hot at bit addr[1:0], with mem_wdata equal to the byte replicated in all four lanes.
REQ-025 WRITE: on mem_ready the FSM shall update the cached word if the store hits (enabled lanes only) and go to DONE; a miss leaves the cache unchanged.
REQ-026 DONE shall last one cycle: stall=0, the held CPU request is ignored, then the FSM returns to IDLE.
REQ-027 cpu_re and cpu_we both high shall be treated as a store.
REQ-028 The CPU shall hold its request stable while stall=1; the cache samples it only in IDLE.
REQ-029 mem_ready shall be ignored in IDLE and DONE.
REQ-030 cpu_rdata shall be 0 whenever the cycle is not an IDLE read hit.

Reset
REQ-031 rst shall force state=IDLE, clear all valid bits, and set stall, mem_req, mem_we, mem_addr, mem_wdata and mem_be to 0 at the next edge.
REQ-032 Reset mid-FILL or mid-WRITE shall abandon the transaction; a late mem_ready shall then be ignored.
REQ-033 Tag and data arrays need no reset.

Structure
REQ-034 A shared package shall hold the state enum, the SETS default, and the index/tag width constants.
REQ-035 One sub-module, cache_byte_lane, shall do byte extract for loads and lane merge/enable generation for stores.

Verification
REQ-036 After reset, load 0x0000_0040 with memory returning 0xDEADBEEF after 3 cycles: stall high 4 cycles, then cpu_rdata=0xDEADBEEF with stall=0.
REQ-037 Repeat load 0x40 immediately: hit in the same cycle, with stall=0 and mem_req never asserted.
REQ-038 Byte store 0xAB to 0x41: mem_be=4'b0010, mem_wdata=0xABABABAB; afterwards load byte 0x41 = 0x000000AB and load word 0x40 = 0xDEADABEF.
REQ-039 Load 0x60, which shares index 0 with 0x40 under SETS=8: miss with refill, and a following load of 0x40 misses again.
REQ-040 Assert rst during FILL, then pulse mem_ready: state remains IDLE, and a load of 0x40 misses.
REQ-041 cpu_re=cpu_we=1 at 0x80: store transaction issued, and the cycle after DONE shows no second mem_req.
